// File: rtl/phy_pkg.sv
// Shared phy constants: line characters (shared with the serializer) and rx state encoding.
package phy_pkg;

    localparam logic [7:0] COMMA_CHAR = 8'hBC;
    localparam logic [7:0] IDLE_CHAR  = 8'h7C;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/phy_comma_detect.sv
// Serial shift history plus the 8-bit window ending at the current bit, with
// comma/idle match flags on that window.
module phy_comma_detect
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA = COMMA_CHAR,
    parameter logic [7:0] IDLE  = IDLE_CHAR
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] window,
    output logic       is_comma,
    output logic       is_idle
);

    // Only the newest 7 bits are ever reused; the oldest bit shifts out unread.
    logic [6:0] sr;

    assign window   = {sr, data_in};
    assign is_comma = (window == COMMA);
    assign is_idle  = (window == IDLE);

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= window[6:0];
        end
    end

endmodule

// File: rtl/phy_rx_deserializer.sv
// Receive deserializer: comma-based byte alignment, sync FSM and byte output registers.
// Build option: define RX_RESYNC_EN to re-align on a misaligned comma while ACTIVE.
module phy_rx_deserializer
    import phy_pkg::*;
#(
    parameter int unsigned BC_COUNT = 4,
    parameter logic [7:0]  COMMA    = COMMA_CHAR,
    parameter logic [7:0]  IDLE     = IDLE_CHAR
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strb,
    output logic       active
);

    localparam int unsigned BCW = $clog2(BC_COUNT + 1);
    localparam logic [BCW-1:0] BC_TARGET = BCW'(BC_COUNT);

    rx_state_t      state;
    logic [2:0]     bit_cnt;
    logic [BCW-1:0] bc_seen;
    logic [BCW-1:0] bc_next;
    logic [7:0]     window;
    logic           is_comma;
    logic           is_idle;
    logic           boundary;

    phy_comma_detect #(
        .COMMA (COMMA),
        .IDLE  (IDLE)
    ) u_comma_detect (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .data_in  (data_in),
        .window   (window),
        .is_comma (is_comma),
        .is_idle  (is_idle)
    );

    assign boundary = (bit_cnt == 3'd7);
    assign bc_next  = bc_seen + BCW'(1);

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state     <= SEARCH;
            bit_cnt   <= '0;
            bc_seen   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            byte_strb <= 1'b0;
            active    <= 1'b0;
        end else begin
            byte_strb <= 1'b0;
            bit_cnt   <= bit_cnt + 3'd1;
            case (state)
                SEARCH: begin
                    bit_cnt <= '0;
                    if (is_comma) begin
                        bc_seen <= BCW'(1);
                        if (BC_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        if (is_comma) begin
                            bc_seen <= bc_next;
                            if (bc_next == BC_TARGET) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            bc_seen <= '0;
                            bit_cnt <= '0;
                            state   <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary) begin
                        byte_strb <= 1'b1;
                        if (is_comma || is_idle) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= window;
                            valid_out <= 1'b1;
                        end
                    end
`ifdef RX_RESYNC_EN
                    else if (is_comma) begin
                        state     <= ALIGN;
                        bit_cnt   <= '0;
                        bc_seen   <= BCW'(1);
                        active    <= 1'b0;
                        valid_out <= 1'b0;
                    end
`endif
                end
                default: begin
                    state   <= SEARCH;
                    bit_cnt <= '0;
                    bc_seen <= '0;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule
